// File: rtl/sram_1rw1r_sync_param.sv
// -----------------------------------------------------------------------------
// sram_1rw1r_sync_param
// Parametrised single-clock SRAM with one read/write port (0) and one
// read-only port (1). Writes are lane-masked. Reads return data after
// READ_LATENCY (1 or 2) cycles, along with a one-cycle valid strobe. After
// reset the array can optionally be zero-filled, and 'busy' is high while that
// runs.
//
// Parameters:
//   DATA_WIDTH    word width in bits (must be a multiple of WMASK_WIDTH)
//   ADDR_WIDTH    address bits; depth = 1 << ADDR_WIDTH
//   WMASK_WIDTH   bits per write-mask lane
//   READ_LATENCY  1 or 2 cycles from request to dout/dvalid
//   INIT_ON_RESET 1: zero-fill the array after reset, 0: leave contents alone
//   WRITE_FIRST   1: a port-1 read that collides with a port-0 write returns
//                 the merged new word; 0: it returns the pre-write word
//
// Ports:
//   clk0                  clock (rising edge)
//   rstb0                 synchronous reset, active low
//   busy                  high while the zero-fill runs (requests are dropped)
//   csb0/web0             port 0 select / write enable, both active low
//   wmask0/addr0/din0     port 0 lane mask, address and write data
//   dout0/dvalid0         port 0 read data and one-cycle valid strobe
//   csb1/addr1            port 1 select (active low) and address
//   dout1/dvalid1         port 1 read data and one-cycle valid strobe
//   collision1            (only with SRAM_COLLISION_FLAG_EN) high alongside
//                         dvalid1 when that read hit a same-cycle port-0 write
//
// Optional feature macro: SRAM_COLLISION_FLAG_EN
// -----------------------------------------------------------------------------
module sram_1rw1r_sync_param #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 9,
    parameter int WMASK_WIDTH   = 8,
    parameter int READ_LATENCY  = 1,
    parameter int INIT_ON_RESET = 1,
    parameter int WRITE_FIRST   = 1,
    localparam int NUM_WMASKS   = DATA_WIDTH / WMASK_WIDTH
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    output logic                  busy,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dvalid0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dvalid1
`ifdef SRAM_COLLISION_FLAG_EN
    ,
    output logic                  collision1
`endif
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   fill_cnt_reg;
    logic                    busy_reg;

    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    // Fill sequencer. The counter is all ones exactly when the last word is
    // being written, so that edge is also the one where busy falls.
    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            fill_cnt_reg <= '0;
            state_reg    <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
            busy_reg     <= (INIT_ON_RESET != 0);
        end else if (state_reg == ST_INIT) begin
            fill_cnt_reg <= fill_cnt_reg + 1'b1;
            if (&fill_cnt_reg) begin
                state_reg <= ST_READY;
                busy_reg  <= 1'b0;
            end
        end
    end

    assign busy = busy_reg;

    // Requests count only in READY and never on a reset edge.
    logic ready;
    logic wr_en;
    logic rd0_en;
    logic rd1_en;
    logic collide;

    assign ready   = rstb0 && (state_reg == ST_READY);
    assign wr_en   = ready && !csb0 && !web0;
    assign rd0_en  = ready && !csb0 && web0;
    assign rd1_en  = ready && !csb1;
    assign collide = wr_en && rd1_en && (addr0 == addr1);

    // Expand the per-lane mask into a per-bit mask.
    logic [DATA_WIDTH-1:0] wbits;
    generate
        for (genvar gi = 0; gi < NUM_WMASKS; gi++) begin : g_lane
            assign wbits[gi*WMASK_WIDTH +: WMASK_WIDTH] = {WMASK_WIDTH{wmask0[gi]}};
        end
    endgenerate

    // Word as it will look after this cycle's port-0 write; also what a
    // colliding write-first port-1 read returns.
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] rd1_word;

    assign merged_word = (mem[addr0] & ~wbits) | (din0 & wbits);
    assign rd1_word    = ((WRITE_FIRST != 0) && collide) ? merged_word : mem[addr1];

    // Array writes: the zero-fill owns the array while INIT runs.
    always_ff @(posedge clk0) begin
        if (rstb0 && (state_reg == ST_INIT)) begin
            mem[fill_cnt_reg] <= '0;
        end else if (wr_en) begin
            mem[addr0] <= merged_word;
        end
    end

    // First read stage. Data registers only load on a read so dout holds its
    // last value between reads.
    logic                  v0_s1_reg;
    logic                  v1_s1_reg;
    logic [DATA_WIDTH-1:0] d0_s1_reg;
    logic [DATA_WIDTH-1:0] d1_s1_reg;

    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            v0_s1_reg <= 1'b0;
            v1_s1_reg <= 1'b0;
            d0_s1_reg <= '0;
            d1_s1_reg <= '0;
        end else begin
            v0_s1_reg <= rd0_en;
            v1_s1_reg <= rd1_en;
            if (rd0_en) d0_s1_reg <= mem[addr0];
            if (rd1_en) d1_s1_reg <= rd1_word;
        end
    end

`ifdef SRAM_COLLISION_FLAG_EN
    logic c1_s1_reg;

    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            c1_s1_reg <= 1'b0;
        end else begin
            c1_s1_reg <= collide;
        end
    end
`endif

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            // Output pipeline stage: follows stage 1 one cycle later.
            logic                  v0_s2_reg;
            logic                  v1_s2_reg;
            logic [DATA_WIDTH-1:0] d0_s2_reg;
            logic [DATA_WIDTH-1:0] d1_s2_reg;

            always_ff @(posedge clk0) begin
                if (!rstb0) begin
                    v0_s2_reg <= 1'b0;
                    v1_s2_reg <= 1'b0;
                    d0_s2_reg <= '0;
                    d1_s2_reg <= '0;
                end else begin
                    v0_s2_reg <= v0_s1_reg;
                    v1_s2_reg <= v1_s1_reg;
                    if (v0_s1_reg) d0_s2_reg <= d0_s1_reg;
                    if (v1_s1_reg) d1_s2_reg <= d1_s1_reg;
                end
            end

            assign dout0   = d0_s2_reg;
            assign dvalid0 = v0_s2_reg;
            assign dout1   = d1_s2_reg;
            assign dvalid1 = v1_s2_reg;

`ifdef SRAM_COLLISION_FLAG_EN
            logic c1_s2_reg;

            always_ff @(posedge clk0) begin
                if (!rstb0) begin
                    c1_s2_reg <= 1'b0;
                end else begin
                    c1_s2_reg <= c1_s1_reg;
                end
            end

            assign collision1 = c1_s2_reg;
`endif
        end else begin : g_lat1
            assign dout0   = d0_s1_reg;
            assign dvalid0 = v0_s1_reg;
            assign dout1   = d1_s1_reg;
            assign dvalid1 = v1_s1_reg;
`ifdef SRAM_COLLISION_FLAG_EN
            assign collision1 = c1_s1_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_sram_1rw1r_sync_param.sv
// -----------------------------------------------------------------------------
// tb_sram_1rw1r_sync_param
// Two instances driven by the same inputs: dut_a with default parameters
// (latency 1, write-first) and dut_b with latency 2 and read-first collisions.
// A transaction-level model (word array plus a queue of scheduled read
// results) predicts every output of both instances.
// -----------------------------------------------------------------------------
module tb_sram_1rw1r_sync_param;

    localparam int DEPTH = 512;

    logic clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    logic        rstb0;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [8:0]  addr0;
    logic [31:0] din0;
    logic        csb1;
    logic [8:0]  addr1;

    logic        busy_a, dvalid0_a, dvalid1_a;
    logic [31:0] dout0_a, dout1_a;
    logic        busy_b, dvalid0_b, dvalid1_b;
    logic [31:0] dout0_b, dout1_b;
`ifdef SRAM_COLLISION_FLAG_EN
    logic        coll_a, coll_b;
`endif

    sram_1rw1r_sync_param dut_a (
        .clk0(clk0), .rstb0(rstb0), .busy(busy_a),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(dout0_a), .dvalid0(dvalid0_a),
        .csb1(csb1), .addr1(addr1), .dout1(dout1_a), .dvalid1(dvalid1_a)
`ifdef SRAM_COLLISION_FLAG_EN
        , .collision1(coll_a)
`endif
    );

    sram_1rw1r_sync_param #(.READ_LATENCY(2), .WRITE_FIRST(0)) dut_b (
        .clk0(clk0), .rstb0(rstb0), .busy(busy_b),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(dout0_b), .dvalid0(dvalid0_b),
        .csb1(csb1), .addr1(addr1), .dout1(dout1_b), .dvalid1(dvalid1_b)
`ifdef SRAM_COLLISION_FLAG_EN
        , .collision1(coll_b)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        int          dut;
        int          port;
        logic [31:0] data;
        bit          coll;
    } pend_t;

    logic [31:0] m_mem [DEPTH];
    bit          m_busy;
    int          m_fill;
    int          cyc;
    pend_t       pend_q[$];
    logic        e_dv0 [2];
    logic        e_dv1 [2];
    logic        e_c1  [2];
    logic [31:0] e_d0  [2];
    logic [31:0] e_d1  [2];

    logic [133:0] exp_vec;
    wire  [133:0] obs_vec = {busy_a, dvalid0_a, dout0_a, dvalid1_a, dout1_a,
                             busy_b, dvalid0_b, dout0_b, dvalid1_b, dout1_b};

    int n_checks;
    int n_pass;
    logic [8:0] junk_addr;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  m);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++)
            if (m[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        return r;
    endfunction

    // Predict the effect of the coming rising edge, advance the clock, then
    // publish the outputs expected just after that edge.
    task automatic tick();
        logic [31:0] old0, old1, merged;
        bit          wr, coll;
        pend_t       p;
        if (rstb0 !== 1'b1) begin
            pend_q.delete();
            m_busy = 1'b1;
            m_fill = 0;
            for (int d = 0; d < 2; d++) begin
                e_d0[d] = '0;
                e_d1[d] = '0;
            end
        end else if (m_busy) begin
            m_mem[m_fill] = '0;
            m_fill++;
            if (m_fill == DEPTH) m_busy = 1'b0;
        end else begin
            old0   = m_mem[addr0];
            old1   = m_mem[addr1];
            wr     = !csb0 && !web0;
            merged = lane_merge(old0, din0, wmask0);
            if (!csb0 && web0) begin
                p.port = 0; p.data = old0; p.coll = 1'b0;
                p.dut = 0; p.due = cyc + 1; pend_q.push_back(p);
                p.dut = 1; p.due = cyc + 2; pend_q.push_back(p);
            end
            if (!csb1) begin
                coll   = wr && (addr0 == addr1);
                p.port = 1; p.coll = coll;
                p.dut = 0; p.due = cyc + 1; p.data = coll ? merged : old1; pend_q.push_back(p);
                p.dut = 1; p.due = cyc + 2; p.data = old1;                 pend_q.push_back(p);
            end
            if (wr) m_mem[addr0] = merged;
        end
        @(posedge clk0);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            e_dv0[d] = 1'b0;
            e_dv1[d] = 1'b0;
            e_c1[d]  = 1'b0;
        end
        for (int i = pend_q.size() - 1; i >= 0; i--) begin
            if (pend_q[i].due == cyc) begin
                p = pend_q[i];
                if (p.port == 0) begin
                    e_dv0[p.dut] = 1'b1;
                    e_d0[p.dut]  = p.data;
                end else begin
                    e_dv1[p.dut] = 1'b1;
                    e_d1[p.dut]  = p.data;
                    e_c1[p.dut]  = p.coll;
                end
                pend_q.delete(i);
            end
        end
        exp_vec = {m_busy, e_dv0[0], e_d0[0], e_dv1[0], e_d1[0],
                   m_busy, e_dv0[1], e_d0[1], e_dv1[1], e_d1[1]};
    endtask

    task automatic set_idle();
        csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = '0; din0 = '0;
        csb1 = 1'b1; addr1 = '0;
    endtask

    task automatic write0(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
        $display("write  addr=%h data=%h mask=%b", a, d, m);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_idle();
        rstb0 = 1'b0;
        tick();
        tick();
        n_checks++;
        if (obs_vec !== exp_vec)
            $display("FAIL reset_state cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
        else n_pass++;
        n_checks++;
        if (busy_a !== 1'b1) $display("FAIL reset_busy got=%b want=1", busy_a);
        else n_pass++;
        $display("reset  busy=%b dout0=%h dvalid0=%b", busy_a, dout0_a, dvalid0_a);
    endtask

    // Releases reset and runs the zero-fill with junk requests applied; they
    // must all be ignored. Counts rising edges until busy falls.
    task automatic test_init_fill();
        int edges;
        int errs;
        edges = 0;
        errs  = 0;
        rstb0 = 1'b1;
        for (int i = 0; i < DEPTH + 20; i++) begin
            csb0 = 1'(($urandom & 3) == 0);
            web0 = 1'($urandom);
            wmask0 = 4'hF;
            addr0 = 9'($urandom_range(0, 31));
            din0 = $urandom | 32'h1;
            csb1 = 1'($urandom);
            addr1 = 9'($urandom);
            if (!csb0 && !web0) junk_addr = addr0;
            tick();
            edges++;
            if (obs_vec !== exp_vec) begin
                errs++;
                if (errs < 4)
                    $display("FAIL fill_cycle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
            if (busy_a !== 1'b1) break;
        end
        set_idle();
        n_checks++;
        if (errs != 0) $display("FAIL fill_outputs bad_cycles=%0d want=0", errs);
        else n_pass++;
        n_checks++;
        if (edges != DEPTH) $display("FAIL fill_length got=%0d want=%0d", edges, DEPTH);
        else n_pass++;
        $display("fill   busy_edges=%0d", edges);
    endtask

    task automatic test_read_zero();
        logic [8:0] a0 [3];
        logic [8:0] a1 [3];
        a0[0] = 9'h000; a1[0] = 9'h1FF;
        a0[1] = 9'h1FF; a1[1] = 9'h000;
        a0[2] = junk_addr; a1[2] = junk_addr;
        for (int k = 0; k < 3; k++) begin
            csb0 = 1'b0; web0 = 1'b1; addr0 = a0[k];
            csb1 = 1'b0; addr1 = a1[k];
            tick();
            set_idle();
            n_checks++;
            if (dvalid0_a !== 1'b1 || dout0_a !== 32'h0 || dvalid1_a !== 1'b1 || dout1_a !== 32'h0)
                $display("FAIL read_zero_a addr=%h got=%b/%h %b/%h want=1/00000000", a0[k], dvalid0_a, dout0_a, dvalid1_a, dout1_a);
            else n_pass++;
            tick();
            n_checks++;
            if (obs_vec !== exp_vec)
                $display("FAIL read_zero_b cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            else n_pass++;
            $display("read   addr0=%h addr1=%h dout0=%h dout1=%h", a0[k], a1[k], dout0_a, dout1_a);
        end
        tick();
    endtask

    task automatic test_masked_write();
        write0(9'h010, 32'hDEADBEEF, 4'b1111);
        tick();
        write0(9'h010, 32'h11223344, 4'b0101);
        tick();
        set_idle();
        csb0 = 1'b0; web0 = 1'b1; addr0 = 9'h010;
        tick();
        set_idle();
        n_checks++;
        if (dout0_a !== 32'hDE22BE44 || dvalid0_a !== 1'b1)
            $display("FAIL masked_read got=%h/%b want=de22be44/1", dout0_a, dvalid0_a);
        else n_pass++;
        tick();
        n_checks++;
        if (obs_vec !== exp_vec)
            $display("FAIL masked_read_lat2 cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
        else n_pass++;
        $display("read   addr=010 dout0_a=%h dout0_b=%h", dout0_a, dout0_b);
        tick();
    endtask

    task automatic test_collision();
        write0(9'h020, 32'h01234567, 4'b1111);
        tick();
        write0(9'h020, 32'hCAFEF00D, 4'b1100);
        csb1 = 1'b0; addr1 = 9'h020;
        tick();
        set_idle();
        n_checks++;
        if (dout1_a !== 32'hCAFE4567 || dvalid1_a !== 1'b1)
            $display("FAIL collision_wf got=%h/%b want=cafe4567/1", dout1_a, dvalid1_a);
        else n_pass++;
`ifdef SRAM_COLLISION_FLAG_EN
        n_checks++;
        if (coll_a !== 1'b1) $display("FAIL collision_flag_a got=%b want=1", coll_a);
        else n_pass++;
`endif
        tick();
        n_checks++;
        if (dout1_b !== 32'h01234567 || dvalid1_b !== 1'b1)
            $display("FAIL collision_rf got=%h/%b want=01234567/1", dout1_b, dvalid1_b);
        else n_pass++;
`ifdef SRAM_COLLISION_FLAG_EN
        n_checks++;
        if (coll_b !== 1'b1) $display("FAIL collision_flag_b got=%b want=1", coll_b);
        else n_pass++;
`endif
        $display("collide addr=020 dout1_a=%h dout1_b=%h", dout1_a, dout1_b);
        tick();
        n_checks++;
        if (obs_vec !== exp_vec)
            $display("FAIL collision_after cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int vb;
        for (int k = 1; k <= 3; k++) begin
            write0(9'(k), $urandom, 4'hF);
            tick();
        end
        vb = 0;
        for (int k = 1; k <= 6; k++) begin
            set_idle();
            if (k <= 3) begin
                csb0 = 1'b0; web0 = 1'b1; addr0 = 9'(k);
            end
            tick();
            if (dvalid0_b === 1'b1) vb++;
            n_checks++;
            if (obs_vec !== exp_vec)
                $display("FAIL back_to_back cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            else n_pass++;
            $display("b2b    step=%0d dout0_a=%h dout0_b=%h dvalid0_b=%b", k, dout0_a, dout0_b, dvalid0_b);
        end
        n_checks++;
        if (vb != 3) $display("FAIL b2b_valid_count got=%0d want=3", vb);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            csb0   = 1'($urandom_range(0, 3) == 0);
            web0   = 1'($urandom);
            wmask0 = 4'($urandom);
            addr0  = 9'(9'h040 + $urandom_range(0, 7));
            din0   = $urandom;
            csb1   = 1'($urandom_range(0, 2) == 0);
            addr1  = ($urandom_range(0, 3) == 0) ? addr0 : 9'(9'h040 + $urandom_range(0, 7));
            tick();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                errs++;
                if (errs < 6)
                    $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end else n_pass++;
`ifdef SRAM_COLLISION_FLAG_EN
            n_checks++;
            if ({coll_a, coll_b} !== {e_c1[0], e_c1[1]})
                $display("FAIL random_collision cyc=%0d got=%b%b want=%b%b", cyc, coll_a, coll_b, e_c1[0], e_c1[1]);
            else n_pass++;
`endif
        end
        set_idle();
        tick();
        tick();
        $display("random 400 cycles, mismatching cycles=%0d", errs);
    endtask

    task automatic test_reset_mid_read();
        csb0 = 1'b0; web0 = 1'b1; addr0 = 9'h010;
        csb1 = 1'b0; addr1 = 9'h020;
        tick();
        set_idle();
        rstb0 = 1'b0;
        tick();
        rstb0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (dvalid0_a !== 1'b0 || dout0_a !== 32'h0 || dvalid0_b !== 1'b0 || dout0_b !== 32'h0 || dvalid1_b !== 1'b0)
                $display("FAIL reset_mid_read k=%0d got=%b/%h %b/%h want=0/00000000", k, dvalid0_a, dout0_a, dvalid0_b, dout0_b);
            else n_pass++;
            tick();
        end
        $display("reset  during read, outputs cleared");
    endtask

    task automatic test_reset_mid_init();
        // test_reset_mid_read left a fill running; it has done 4 words.
        for (int k = 0; k < 96; k++) tick();
        n_checks++;
        if (m_fill != 100 || busy_a !== 1'b1)
            $display("FAIL mid_init_pos fill=%0d busy=%b want=100/1", m_fill, busy_a);
        else n_pass++;
        rstb0 = 1'b0;
        tick();
        n_checks++;
        if (obs_vec !== exp_vec)
            $display("FAIL mid_init_reset cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
        else n_pass++;
        $display("reset  at fill count 100");
        test_init_fill();
        // The earlier write to 0x010 must be gone after the second fill.
        csb0 = 1'b0; web0 = 1'b1; addr0 = 9'h010;
        tick();
        set_idle();
        n_checks++;
        if (dout0_a !== 32'h0 || dvalid0_a !== 1'b1)
            $display("FAIL refill_zero got=%h/%b want=00000000/1", dout0_a, dvalid0_a);
        else n_pass++;
        tick();
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        cyc       = 0;
        m_busy    = 1'b0;
        m_fill    = 0;
        junk_addr = '0;
        exp_vec   = '0;
        for (int d = 0; d < 2; d++) begin
            e_dv0[d] = 1'b0; e_dv1[d] = 1'b0; e_c1[d] = 1'b0;
            e_d0[d] = '0; e_d1[d] = '0;
        end
        rstb0 = 1'b0;
        set_idle();
        #2;
        test_reset();
        test_init_fill();
        test_read_zero();
        test_masked_write();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        test_reset_mid_init();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1, "timeout");
    end

endmodule
